// File: rtl/xadac_vmacc_arbiter.sv
// Round-robin arbiter sharing one xadac vmacc stage between NumSlv issue ports.
// Responses are steered back in order through a route FIFO, with a same-cycle bypass for zero-latency stages.
module xadac_vmacc_arbiter #(
    parameter int NumSlv         = 4,
    parameter int MaxOutstanding = 4,
    parameter int ReqW           = 52,
    parameter int RespW          = 20
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NumSlv-1:0]              i_slv_req_valid,
    output logic [NumSlv-1:0]              o_slv_req_ready,
    input  logic [NumSlv-1:0][ReqW-1:0]    i_slv_req_pld,
    output logic [NumSlv-1:0]              o_slv_resp_valid,
    input  logic [NumSlv-1:0]              i_slv_resp_ready,
    output logic [RespW-1:0]               o_slv_resp_pld,
    output logic                           o_mst_req_valid,
    input  logic                           i_mst_req_ready,
    output logic [ReqW-1:0]                o_mst_req_pld,
    input  logic                           i_mst_resp_valid,
    output logic                           o_mst_resp_ready,
    input  logic [RespW-1:0]               i_mst_resp_pld
);

    localparam int SelW = $clog2(NumSlv);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [SelW-1:0] r_rr_ptr;
    logic            r_lock;
    logic [SelW-1:0] r_lock_idx;
    logic [SelW-1:0] r_route_q [MaxOutstanding];
    logic [PtrW-1:0] r_head;
    logic [PtrW-1:0] r_tail;
    logic [CntW-1:0] r_count;

    logic [SelW-1:0] w_grant;
    logic [SelW-1:0] w_route;
    logic            w_found;
    logic            w_full;
    logic            w_empty;
    logic            w_req_hs;
    logic            w_resp_hs;
    logic            w_route_ok;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    int              w_scan;

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        w_grant = r_rr_ptr;
        w_found = 1'b0;
        w_scan  = 0;
        if (r_lock) begin
            w_grant = r_lock_idx;
            w_found = 1'b1;
        end else begin
            for (int k = NumSlv - 1; k >= 0; k--) begin
                w_scan = int'(r_rr_ptr) + k;
                if (w_scan >= NumSlv) w_scan = w_scan - NumSlv;
                if (i_slv_req_valid[SelW'(w_scan)]) begin
                    w_grant = SelW'(w_scan);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_full   = (r_count == CntW'(MaxOutstanding));
    assign w_empty  = (r_count == '0);

    assign o_mst_req_valid = rstn & w_found & i_slv_req_valid[w_grant] & ~w_full;
    assign o_mst_req_pld   = i_slv_req_pld[w_grant];
    assign w_req_hs        = o_mst_req_valid & i_mst_req_ready;

    always_comb begin
        o_slv_req_ready = '0;
        for (int p = 0; p < NumSlv; p++) begin
            o_slv_req_ready[p] = rstn & w_found & i_mst_req_ready & ~w_full & (SelW'(p) == w_grant);
        end
    end

    // An empty FIFO can only route a response that belongs to this cycle's request.
    assign w_route    = w_empty ? w_grant : r_route_q[r_head];
    assign w_route_ok = ~w_empty | w_req_hs;
    assign w_drop     = i_mst_resp_valid & ~w_route_ok;

    always_comb begin
        o_slv_resp_valid = '0;
        for (int p = 0; p < NumSlv; p++) begin
            o_slv_resp_valid[p] = rstn & i_mst_resp_valid & w_route_ok & (SelW'(p) == w_route);
        end
    end

    assign o_slv_resp_pld   = i_mst_resp_pld;
    assign o_mst_resp_ready = rstn & (w_drop | (w_route_ok & i_slv_resp_ready[w_route]));
    assign w_resp_hs        = i_mst_resp_valid & o_mst_resp_ready;

    assign w_pop  = w_resp_hs & ~w_empty;
    assign w_push = w_req_hs & ~(w_empty & w_resp_hs);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int i = 0; i < MaxOutstanding; i++) r_route_q[i] <= '0;
        end else begin
            r_lock <= o_mst_req_valid & ~i_mst_req_ready;
            if (o_mst_req_valid & ~i_mst_req_ready) r_lock_idx <= w_grant;
            if (w_req_hs) begin
                r_rr_ptr <= (w_grant == SelW'(NumSlv - 1)) ? '0 : w_grant + SelW'(1);
            end
            if (w_push) begin
                r_route_q[r_tail] <= w_grant;
                r_tail <= (r_tail == PtrW'(MaxOutstanding - 1)) ? '0 : r_tail + PtrW'(1);
            end
            if (w_pop) begin
                r_head <= (r_head == PtrW'(MaxOutstanding - 1)) ? '0 : r_head + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
        r_count <= CntW'(MaxOutstanding));

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rstn)
        i_mst_resp_valid |-> w_route_ok);

    a_locked_pld_stable: assert property (@(posedge clk) disable iff (!rstn)
        r_lock |-> (o_mst_req_pld == $past(o_mst_req_pld)));

endmodule

// File: tb/tb_xadac_vmacc_arbiter.sv
// Directed bench for xadac_vmacc_arbiter: vector table for grant order plus hand sequences
// for lock, FIFO-full, response back-pressure and mid-burst reset, with a behavioural vmacc stage.
module tb_xadac_vmacc_arbiter;

    logic             clk = 1'b0;
    logic             rstn;
    logic [3:0]       slv_req_valid, slv_req_ready, slv_resp_valid, slv_resp_ready;
    logic [3:0][51:0] slv_req_pld;
    logic [19:0]      slv_resp_pld, mst_resp_pld;
    logic             mst_req_valid, mst_req_ready, mst_resp_valid, mst_resp_ready;
    logic [51:0]      mst_req_pld;
    logic             lat0;
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;

    always #5 clk = ~clk;

    xadac_vmacc_arbiter #(.NumSlv(4), .MaxOutstanding(4), .ReqW(52), .RespW(20)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_slv_req_valid  (slv_req_valid),
        .o_slv_req_ready  (slv_req_ready),
        .i_slv_req_pld    (slv_req_pld),
        .o_slv_resp_valid (slv_resp_valid),
        .i_slv_resp_ready (slv_resp_ready),
        .o_slv_resp_pld   (slv_resp_pld),
        .o_mst_req_valid  (mst_req_valid),
        .i_mst_req_ready  (mst_req_ready),
        .o_mst_req_pld    (mst_req_pld),
        .i_mst_resp_valid (mst_resp_valid),
        .o_mst_resp_ready (mst_resp_ready),
        .i_mst_resp_pld   (mst_resp_pld)
    );

    // Request {id, vs1, vs2, vs3}; response {id, vd}, vd = vs3 + dot of four 4-bit lanes.
    function automatic logic [19:0] stage_fn(input logic [51:0] r);
        logic [15:0] vs1, vs2, acc;
        vs1 = r[47:32];
        vs2 = r[31:16];
        acc = r[15:0];
        for (int l = 0; l < 4; l++) acc = acc + ({12'd0, vs1[4*l +: 4]} * {12'd0, vs2[4*l +: 4]});
        return {r[51:48], acc};
    endfunction

    function automatic logic [51:0] mk(input int p, input int k);
        logic [3:0] id;
        id = 4'((p << 2) | (k & 3));
        return {id, 16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // vmacc stage: zero-latency (combinational) or 2-cycle in-order pipeline.
    logic [19:0] sq_pld [$];
    int          sq_t   [$];
    logic        st_vld;
    logic [19:0] st_pld;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sq_pld.delete();
            sq_t.delete();
            st_vld <= 1'b0;
            st_pld <= '0;
        end else begin
            cyc++;
            if (!lat0) begin
                if (mst_resp_valid && mst_resp_ready) begin
                    void'(sq_pld.pop_front());
                    void'(sq_t.pop_front());
                end
                if (mst_req_valid && mst_req_ready) begin
                    sq_pld.push_back(stage_fn(mst_req_pld));
                    sq_t.push_back(cyc + 1);
                end
            end
            st_vld <= (sq_t.size() > 0) && (sq_t[0] <= cyc);
            st_pld <= (sq_pld.size() > 0) ? sq_pld[0] : 20'd0;
        end
    end

    assign mst_resp_valid = lat0 ? (mst_req_valid & mst_req_ready) : st_vld;
    assign mst_resp_pld   = lat0 ? stage_fn(mst_req_pld) : st_pld;

    // Per-port scoreboard: every delivered response must be the oldest one owed to that port.
    logic [19:0] expq [4][$];

    always @(posedge clk) begin
        if (!rstn) begin
            for (int p = 0; p < 4; p++) expq[p].delete();
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (slv_req_valid[p] && slv_req_ready[p]) expq[p].push_back(stage_fn(slv_req_pld[p]));
                if (slv_resp_valid[p] && slv_resp_ready[p]) begin
                    if (expq[p].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL route_p%0d: got unexpected resp %0h, expected no response", p, slv_resp_pld);
                    end else begin
                        chk($sformatf("resp_p%0d", p), 64'(slv_resp_pld), 64'(expq[p].pop_front()));
                    end
                end
            end
        end
    end

    function automatic int owed();
        return expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 30 && owed() != 0; k++) step();
        chk(nm, 64'(owed()), 64'd0);
    endtask

    typedef struct {
        logic [3:0] vmask;
        logic [3:0] exp_rdy;
    } vec_t;

    vec_t        tbl [14];
    logic [51:0] p1;
    int          g;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'hF, 4'h1};
        tbl[1]  = '{4'hF, 4'h2};
        tbl[2]  = '{4'hF, 4'h4};
        tbl[3]  = '{4'hF, 4'h8};
        tbl[4]  = '{4'hF, 4'h1};
        tbl[5]  = '{4'h0, 4'h0};
        tbl[6]  = '{4'h8, 4'h8};
        tbl[7]  = '{4'h8, 4'h8};
        tbl[8]  = '{4'h3, 4'h1};
        tbl[9]  = '{4'h6, 4'h2};
        tbl[10] = '{4'h3, 4'h1};
        tbl[11] = '{4'hA, 4'h2};
        tbl[12] = '{4'h9, 4'h8};
        tbl[13] = '{4'h0, 4'h0};

        rstn           = 1'b0;
        lat0           = 1'b1;
        slv_req_valid  = 4'hF;
        slv_resp_ready = 4'hF;
        mst_req_ready  = 1'b1;
        for (int p = 0; p < 4; p++) slv_req_pld[p] = mk(p, 0);
        #12;
        chk("rst_mst_req_valid", 64'(mst_req_valid), 64'd0);
        chk("rst_slv_req_ready", 64'(slv_req_ready), 64'd0);
        chk("rst_slv_resp_valid", 64'(slv_resp_valid), 64'd0);
        chk("rst_mst_resp_ready", 64'(mst_resp_ready), 64'd0);
        slv_req_valid = 4'h0;
        rstn = 1'b1;
        step();

        // Round-robin order and no-idle-skip grant, zero-latency stage.
        for (int i = 0; i < 14; i++) begin
            slv_req_valid = tbl[i].vmask;
            for (int p = 0; p < 4; p++) slv_req_pld[p] = mk(p, i);
            g = -1;
            for (int b = 0; b < 4; b++) if (tbl[i].exp_rdy[b]) g = b;
            @(negedge clk);
            chk($sformatf("v%0d_req_ready", i), 64'(slv_req_ready), 64'(tbl[i].exp_rdy));
            chk($sformatf("v%0d_mst_valid", i), 64'(mst_req_valid), 64'(|tbl[i].exp_rdy));
            chk($sformatf("v%0d_resp_valid", i), 64'(slv_resp_valid), 64'(tbl[i].exp_rdy));
            if (g >= 0) begin
                chk($sformatf("v%0d_mst_pld", i), 64'(mst_req_pld), 64'(slv_req_pld[g]));
                chk($sformatf("v%0d_resp_pld", i), 64'(slv_resp_pld), 64'(stage_fn(slv_req_pld[g])));
            end
            step();
        end

        // Lock: slv1 presented with back-pressure while slv0 joins.
        slv_req_valid  = 4'b0010;
        mst_req_ready  = 1'b0;
        slv_req_pld[1] = mk(1, 1);
        p1             = slv_req_pld[1];
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                slv_req_valid  = 4'b0011;
                slv_req_pld[0] = mk(0, c);
            end
            @(negedge clk);
            chk($sformatf("lock%0d_mst_valid", c), 64'(mst_req_valid), 64'd1);
            chk($sformatf("lock%0d_mst_pld", c), 64'(mst_req_pld), 64'(p1));
            chk($sformatf("lock%0d_req_ready", c), 64'(slv_req_ready), 64'd0);
            step();
        end
        mst_req_ready = 1'b1;
        @(negedge clk);
        chk("lock_hs_req_ready", 64'(slv_req_ready), 64'b0010);
        chk("lock_hs_resp_valid", 64'(slv_resp_valid), 64'b0010);
        step();
        slv_req_pld[1] = mk(1, 2);
        @(negedge clk);
        chk("lock_next_grant", 64'(slv_req_ready), 64'b0001);
        step();
        slv_req_valid = 4'h0;
        step();

        // FIFO full: slv2 streams into a 2-cycle stage with its response held off.
        lat0           = 1'b0;
        slv_resp_ready = 4'b1011;
        step();
        for (int k = 0; k < 4; k++) begin
            slv_req_valid  = 4'b0100;
            slv_req_pld[2] = mk(2, k);
            @(negedge clk);
            chk($sformatf("fill%0d_req_ready", k), 64'(slv_req_ready), 64'b0100);
            step();
        end
        slv_req_pld[2] = mk(2, 4);
        @(negedge clk);
        chk("full_req_ready", 64'(slv_req_ready), 64'd0);
        chk("full_mst_valid", 64'(mst_req_valid), 64'd0);
        chk("full_resp_valid", 64'(slv_resp_valid), 64'b0100);
        chk("full_mst_resp_ready", 64'(mst_resp_ready), 64'd0);
        step();
        slv_resp_ready = 4'hF;
        @(negedge clk);
        chk("full_pop_req_ready", 64'(slv_req_ready), 64'd0);
        chk("full_pop_mst_resp_ready", 64'(mst_resp_ready), 64'd1);
        step();
        @(negedge clk);
        chk("unblock_req_ready", 64'(slv_req_ready), 64'b0100);
        step();
        slv_req_valid = 4'h0;
        drain("drain_full");

        // Response back-pressure on slv3 must not leak slv0's response.
        slv_resp_ready = 4'b0111;
        slv_req_valid  = 4'b1000;
        slv_req_pld[3] = mk(3, 0);
        @(negedge clk);
        chk("il0_req_ready", 64'(slv_req_ready), 64'b1000);
        step();
        slv_req_valid  = 4'b0001;
        slv_req_pld[0] = mk(0, 1);
        @(negedge clk);
        chk("il1_req_ready", 64'(slv_req_ready), 64'b0001);
        step();
        slv_req_valid  = 4'b1000;
        slv_req_pld[3] = mk(3, 2);
        @(negedge clk);
        chk("il2_req_ready", 64'(slv_req_ready), 64'b1000);
        chk("il2_resp_valid", 64'(slv_resp_valid), 64'b1000);
        chk("il2_mst_resp_ready", 64'(mst_resp_ready), 64'd0);
        step();
        slv_req_valid = 4'h0;
        @(negedge clk);
        chk("il3_resp_valid", 64'(slv_resp_valid), 64'b1000);
        chk("il3_mst_resp_ready", 64'(mst_resp_ready), 64'd0);
        step();
        slv_resp_ready = 4'hF;
        @(negedge clk);
        chk("il4_resp_valid", 64'(slv_resp_valid), 64'b1000);
        chk("il4_mst_resp_ready", 64'(mst_resp_ready), 64'd1);
        step();
        @(negedge clk);
        chk("il5_resp_valid", 64'(slv_resp_valid), 64'b0001);
        step();
        @(negedge clk);
        chk("il6_resp_valid", 64'(slv_resp_valid), 64'b1000);
        step();
        drain("drain_interleave");

        // Reset mid-burst with three responses outstanding for slv1.
        slv_resp_ready = 4'b1101;
        slv_req_valid  = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            slv_req_pld[1] = mk(1, k);
            @(negedge clk);
            chk($sformatf("rb%0d_req_ready", k), 64'(slv_req_ready), 64'b0010);
            step();
        end
        slv_req_valid = 4'h0;
        #2;
        rstn          = 1'b0;
        slv_req_valid = 4'hF;
        #1;
        chk("mid_rst_mst_req_valid", 64'(mst_req_valid), 64'd0);
        chk("mid_rst_slv_req_ready", 64'(slv_req_ready), 64'd0);
        chk("mid_rst_slv_resp_valid", 64'(slv_resp_valid), 64'd0);
        chk("mid_rst_mst_resp_ready", 64'(mst_resp_ready), 64'd0);
        step();
        step();
        rstn           = 1'b1;
        slv_resp_ready = 4'hF;
        for (int p = 0; p < 4; p++) slv_req_pld[p] = mk(p, 3);
        @(negedge clk);
        chk("post_rst_grant", 64'(slv_req_ready), 64'b0001);
        step();
        slv_req_valid = 4'h0;
        step();
        @(negedge clk);
        chk("post_rst_resp_valid", 64'(slv_resp_valid), 64'b0001);
        step();
        drain("drain_post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
